// File: rtl/inv_arbiter_pkg.sv
// Shared types and constants for the inv_arbiter round-robin inversion sequencer.
package inv_arbiter_pkg;

  typedef enum logic {EMPTY, FULL} inv_arb_state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment for the per-requester grant counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/inv_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping at NREQ-1.
module inv_arbiter_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && valid[IDW'(cand)]) begin
        grant[IDW'(cand)] = 1'b1;
        idx               = IDW'(cand);
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_arbiter.sv
// Round-robin arbiter sharing one registered bit-inversion stage among NREQ requesters.
// Optional per-requester saturating grant counters under INV_ARBITER_GRANT_CNT_EN.
module inv_arbiter
  import inv_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
`ifdef INV_ARBITER_GRANT_CNT_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  inv_arb_state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            any_valid;
  logic            accept;
  logic            push;
  logic            pop;

  inv_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_valid)
  );

  // Pass-through backpressure: a held result may leave in the same cycle a new one enters.
  assign accept    = (state_q == EMPTY) | resp_ready;
  assign push      = rst_n & accept & any_valid;
  assign pop       = (state_q == FULL) & resp_ready;
  assign req_ready = push ? grant : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (push) begin
      data_d  = ~req_data[win_idx*W +: W];
      id_d    = win_idx;
      ptr_d   = win_idx;
      state_d = FULL;
    end else if (pop) begin
      state_d = EMPTY;
    end
  end

  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= IDW'(NREQ - 1);
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign busy       = (state_q == FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;

`ifdef INV_ARBITER_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && (win_idx == IDW'(i))) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_inv_arbiter.sv
// Directed self-checking bench for inv_arbiter (NREQ=4, W=8).
module tb_inv_arbiter;
  import inv_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;
`ifdef INV_ARBITER_GRANT_CNT_EN
  logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inv_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
`ifdef INV_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order after a single grant to requester 2, and ~operand per requester.
  logic [1:0] exp_id [6]  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] inv_tab [4] = '{8'h0F, 8'hFE, 8'hAD, 8'h5C};

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = '0;
    resp_ready = 1'b0;
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_resp_data",  32'(resp_data),  32'h0);
    chk("rst_resp_id",    32'(resp_id),    32'h0);
    chk("rst_req_ready",  32'(req_ready),  32'h0);

    step();
    rst_n      = 1'b1;
    req_valid  = 4'b0100;
    req_data   = 32'h003C_0000;
    resp_ready = 1'b1;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h4);
    step();
    chk("single_valid", 32'(resp_valid), 32'h1);
    chk("single_data",  32'(resp_data),  32'hC3);
    chk("single_id",    32'(resp_id),    32'h2);

    req_valid = 4'b1111;
    req_data  = 32'hA352_01F0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stream_req_ready", 32'(req_ready), 32'(4'b0001 << exp_id[i]));
      step();
      chk("stream_valid", 32'(resp_valid), 32'h1);
      chk("stream_id",    32'(resp_id),    32'(exp_id[i]));
      chk("stream_data",  32'(resp_data),  32'(inv_tab[exp_id[i]]));
    end

    req_valid = 4'b1000;
    #1;
    chk("ptr_set_ready", 32'(req_ready), 32'h8);
    step();
    chk("ptr_set_id", 32'(resp_id), 32'h3);
    req_valid = 4'b1010;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'h2);
    step();
    chk("wrap_id", 32'(resp_id), 32'h1);
    #1;
    chk("skip_ready", 32'(req_ready), 32'h8);
    step();
    chk("skip_id",   32'(resp_id),   32'h3);
    chk("skip_data", 32'(resp_data), 32'h5C);

    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_data",  32'(resp_data),  32'h5C);
      chk("bp_id",    32'(resp_id),    32'h3);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    chk("popush_valid", 32'(resp_valid), 32'h1);
    chk("popush_id",    32'(resp_id),    32'h1);
    chk("popush_data",  32'(resp_data),  32'hFE);

    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("pop_valid", 32'(resp_valid), 32'h0);
    chk("pop_busy",  32'(busy),       32'h0);
    chk("pop_data",  32'(resp_data),  32'hFE);
    chk("pop_id",    32'(resp_id),    32'h1);

    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    #1;
    chk("fill_ready", 32'(req_ready), 32'h4);
    step();
    chk("fill_valid", 32'(resp_valid), 32'h1);
    chk("fill_id",    32'(resp_id),    32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 32'h0);
    chk("async_rst_data",  32'(resp_data),  32'h0);
    chk("async_rst_id",    32'(resp_id),    32'h0);
    chk("async_rst_ready", 32'(req_ready),  32'h0);
    step();
    rst_n      = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    chk("post_rst_id",   32'(resp_id),   32'h0);
    chk("post_rst_data", 32'(resp_data), 32'h0F);

`ifdef INV_ARBITER_GRANT_CNT_EN
    #2;
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 32'(grant_cnt[31:0]), 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt1_small", 32'(grant_cnt[31:16]), 32'h3);
    repeat (69997) @(posedge clk);
    #1;
    chk("cnt1_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
    chk("cnt0",     32'(grant_cnt[15:0]),  32'h0);
    chk("cnt2",     32'(grant_cnt[47:32]), 32'h0);
    chk("cnt3",     32'(grant_cnt[63:48]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
